alu_issue_sequencer: RTL and testbench

Issue-stage controller for the execute ALU. It accepts one decoded ARM data-processing instruction per handshake and drives the ALU control vector (operation, CV-update class, operand invert/reverse, carry-in). It sequences two-cycle register-shifted-register (RSR) operations and produces the flag and register write enables. It sits between decode and the execute datapath and owns the PrevRSRstate and KeepV controls.

---
 rtl/alu_issue_sequencer.sv | 99 +++++++++
 tb/tb_alu_issue_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer: issue-stage controller that drives the execute ALU control vector and sequences RSR ops.
// Optional macro ALU_SEQ_CFWD_EN forwards the committing carry instead of inserting a hazard bubble.
module alu_issue_sequencer #(
  parameter int RSR_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_opcode,
  input  logic       in_s,
  input  logic       in_rsr,
  input  logic       in_keepv,
  input  logic       flag_c,
  input  logic [3:0] alu_flags,
  input  logic       stall,
  input  logic       flush,
  output logic [2:0] alu_op,
  output logic [2:0] cv_update,
  output logic       invert_b,
  output logic       reverse_inputs,
  output logic       alu_carry,
  output logic       prev_rsr_state,
  output logic       keep_v,
  output logic       ex_valid,
  output logic       flag_write,
  output logic       reg_write
);
  typedef enum logic [1:0] {IDLE, EXEC, RSR1, RSR2} state_t;
  state_t state, state_nx;
  logic       s_q, cmp_q, c_src, carry_hazard, accept, uses_c;
  logic [8:0] dec;
  if (RSR_CYCLES != 2) begin : g_rsr_cycles_unsupported
    $error("alu_issue_sequencer: only RSR_CYCLES == 2 is supported");
  end
  assign uses_c = in_opcode inside {4'b0101, 4'b0110, 4'b0111};
`ifdef ALU_SEQ_CFWD_EN
  logic unused_flags;
  assign unused_flags = ^{alu_flags[3:2], alu_flags[0]};
  assign c_src        = flag_write ? alu_flags[1] : flag_c;
  assign carry_hazard = 1'b0;
`else
  logic unused_flags;
  assign unused_flags = ^alu_flags;
  assign c_src        = flag_c;
  // flag_c is stale while a flag-setting op is still committing
  assign carry_hazard = in_valid & uses_c & s_q & ex_valid;
`endif
  // {alu_op, cv_update, invert_b, reverse_inputs, alu_carry}
  always_comb begin
    dec = 9'b100_000_1_0_0;
    case (in_opcode)
      4'b0000, 4'b1000: dec = 9'b000_000_0_0_0;
      4'b0001, 4'b1001: dec = 9'b001_000_0_0_0;
      4'b0010, 4'b1010: dec = 9'b010_101_1_0_1;
      4'b0011:          dec = 9'b010_101_1_1_1;
      4'b0100:          dec = 9'b010_110_0_0_0;
      4'b0101:          dec = {8'b010_110_0_0, c_src};
      4'b0110:          dec = {8'b010_101_1_0, c_src};
      4'b0111:          dec = {8'b010_101_1_1, c_src};
      4'b1011:          dec = 9'b010_100_0_0_0;
      4'b1100:          dec = 9'b011_000_0_0_0;
      4'b1101:          dec = 9'b100_000_0_0_0;
      4'b1110:          dec = 9'b000_000_1_0_0;
      default:          dec = 9'b100_000_1_0_0;
    endcase
  end
  assign in_ready       = ~stall & (state != RSR1) & ~carry_hazard;
  assign accept         = in_valid & in_ready & ~flush;
  assign ex_valid       = (state == EXEC) | (state == RSR2);
  assign prev_rsr_state = state == RSR2;
  assign flag_write     = ex_valid & s_q;
  assign reg_write      = ex_valid & ~cmp_q;
  always_comb begin
    state_nx = flush ? IDLE : stall ? state : (state == RSR1) ? RSR2 :
               accept ? (in_rsr ? RSR1 : EXEC) : IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      alu_op         <= '0;
      cv_update      <= '0;
      invert_b       <= 1'b0;
      reverse_inputs <= 1'b0;
      alu_carry      <= 1'b0;
      keep_v         <= 1'b0;
      s_q            <= 1'b0;
      cmp_q          <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        {alu_op, cv_update, invert_b, reverse_inputs, alu_carry} <= dec;
        keep_v <= in_keepv & (in_opcode == 4'b0100);
        s_q    <= in_s;
        cmp_q  <= in_opcode[3:2] == 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_sequencer.sv
// tb_alu_issue_sequencer: directed checks of decode, RSR sequencing, carry hazard, stall/flush and reset.
module tb_alu_issue_sequencer;
  logic       clk = 1'b0;
  logic       reset_n, in_valid, in_s, in_rsr, in_keepv, flag_c, stall, flush;
  logic [3:0] in_opcode, alu_flags;
  logic       in_ready, invert_b, reverse_inputs, alu_carry, prev_rsr_state, keep_v;
  logic       ex_valid, flag_write, reg_write;
  logic [2:0] alu_op, cv_update;
  logic [8:0] ctrl;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  assign ctrl = {alu_op, cv_update, invert_b, reverse_inputs, alu_carry};
  alu_issue_sequencer dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_s(in_s), .in_rsr(in_rsr), .in_keepv(in_keepv),
    .flag_c(flag_c), .alu_flags(alu_flags), .stall(stall), .flush(flush),
    .alu_op(alu_op), .cv_update(cv_update), .invert_b(invert_b),
    .reverse_inputs(reverse_inputs), .alu_carry(alu_carry),
    .prev_rsr_state(prev_rsr_state), .keep_v(keep_v), .ex_valid(ex_valid),
    .flag_write(flag_write), .reg_write(reg_write)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic offer(input logic [3:0] op, input logic s, input logic rsr, input logic kv);
    in_valid = 1'b1; in_opcode = op; in_s = s; in_rsr = rsr; in_keepv = kv;
    #1;
  endtask
  task automatic idle;
    in_valid = 1'b0;
    #1;
  endtask
  task automatic chk_status(input string tag, input logic [3:0] exp);
    chk(tag, {12'b0, ex_valid, flag_write, reg_write, prev_rsr_state}, {12'b0, exp});
  endtask
  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_s = 1'b0; in_rsr = 1'b0;
    in_keepv = 1'b0; flag_c = 1'b0; alu_flags = '0; stall = 1'b0; flush = 1'b0;
    #2;
    chk("reset_ready", in_ready, 1);
    chk("reset_status", {ex_valid, flag_write, reg_write, prev_rsr_state, keep_v}, 0);
    chk("reset_ctrl", ctrl, 0);
    @(negedge clk) reset_n = 1'b1;
    tick;
    offer(4'b0010, 1, 0, 0);
    chk("sub_ready", in_ready, 1);
    tick;
    chk("subs_ctrl", ctrl, 9'b010_101_1_0_1);
    chk_status("subs_status", 4'b1110);
    offer(4'b1011, 0, 0, 0);
    chk("cmn_ready", in_ready, 1);
    tick;
    chk("cmn_ctrl", ctrl, 9'b010_100_0_0_0);
    chk_status("cmn_status", 4'b1000);
    offer(4'b1111, 0, 0, 0);
    chk("mvn_ready", in_ready, 1);
    tick;
    chk("mvn_ctrl", ctrl, 9'b100_000_1_0_0);
    chk_status("mvn_status", 4'b1010);
    offer(4'b0011, 0, 1, 0);
    chk("rsb_ready", in_ready, 1);
    tick;
    idle;
    chk("rsr1_ctrl", ctrl, 9'b010_101_1_1_1);
    chk_status("rsr1_status", 4'b0000);
    chk("rsr1_ready", in_ready, 0);
    tick;
    chk_status("rsr2_status", 4'b1011);
    chk("rsr2_reverse", reverse_inputs, 1);
    chk("rsr2_ready", in_ready, 1);
    tick;
    chk_status("rsb_idle", 4'b0000);
    offer(4'b0100, 1, 0, 0);
    tick;
    chk("adds_ctrl", ctrl, 9'b010_110_0_0_0);
    alu_flags = 4'b0010;
    offer(4'b0101, 0, 0, 0);
`ifdef ALU_SEQ_CFWD_EN
    chk("adc_ready", in_ready, 1);
    tick;
    idle;
    alu_flags = 4'b0000;
    chk("adc_fwd_ctrl", ctrl, 9'b010_110_0_0_1);
    chk_status("adc_fwd_status", 4'b1010);
`else
    chk("adc_hazard_ready", in_ready, 0);
    tick;
    alu_flags = 4'b0000;
    #1;
    chk_status("adc_bubble", 4'b0000);
    chk("adc_bubble_ready", in_ready, 1);
    tick;
    idle;
    chk("adc_ctrl", ctrl, 9'b010_110_0_0_0);
    chk_status("adc_status", 4'b1010);
`endif
    offer(4'b0100, 0, 0, 1);
    tick;
    chk("add_keepv", keep_v, 1);
    offer(4'b0010, 0, 0, 1);
    tick;
    chk("sub_keepv", keep_v, 0);
    offer(4'b1000, 1, 0, 0);
    tick;
    idle;
    chk("tst_ctrl", ctrl, 9'b000_000_0_0_0);
    chk_status("tst_status", 4'b1100);
    offer(4'b1100, 1, 1, 0);
    tick;
    idle;
    tick;
    chk("orr_rsr2_ctrl", ctrl, 9'b011_000_0_0_0);
    chk_status("orr_rsr2_status", 4'b1111);
    stall = 1'b1;
    #1;
    chk("stall_ready", in_ready, 0);
    tick;
    chk_status("stall_frozen", 4'b1111);
    flush = 1'b1;
    offer(4'b1101, 0, 0, 0);
    tick;
    flush = 1'b0;
    #1;
    chk_status("flush_idle", 4'b0000);
    chk("flush_ctrl_held", ctrl, 9'b011_000_0_0_0);
    tick;
    chk_status("stall_idle", 4'b0000);
    stall = 1'b0;
    flush = 1'b1;
    #1;
    tick;
    flush = 1'b0;
    idle;
    chk("flush_drops_accept", ctrl, 9'b011_000_0_0_0);
    chk_status("flush_drop_status", 4'b0000);
    chk("post_flush_ready", in_ready, 1);
    offer(4'b0001, 0, 1, 0);
    tick;
    idle;
    chk("eor_rsr1_ctrl", ctrl, 9'b001_000_0_0_0);
    chk("eor_rsr1_ready", in_ready, 0);
    reset_n = 1'b0;
    #1;
    chk("midrsr_reset_ready", in_ready, 1);
    chk("midrsr_reset_status", {ex_valid, flag_write, reg_write, prev_rsr_state, keep_v}, 0);
    chk("midrsr_reset_ctrl", ctrl, 0);
    @(negedge clk) reset_n = 1'b1;
    tick;
    chk_status("after_reset_idle", 4'b0000);
    chk("after_reset_ready", in_ready, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
